round_key_sequencer: RTL and testbench
======================================

Name: round_key_sequencer

Overview:
- Consumer-side controller for the round key repository.
- Requests key expansion and waits for it to complete.
- For each data block, walks the repository's round_count index forward (encrypt) or reverse (decrypt) and streams the registered round keys to the cipher datapath over a valid/ready handshake.
- Sits between the repository and the encrypt/decrypt round datapath.

Parameters:
- TIMEOUT_CYC, 255: maximum EXPAND cycles before abort (used only with the optional feature).

Ports:
- mclk  in  1  master clock, all logic on rising edge
- arst_n  in  1  asynchronous active-low reset
- keylength128  in  1  key length select, priority 128 > 192 > 256
- keylength192  in  1  key length select
- keylength256  in  1  key length select
- new_key  in  1  pulse: expand a new cipher key
- start_exp  out  1  one-cycle start pulse to the repository
- busy_exp  in  1  expansion busy from the repository
- roundkey_in  in  128  [0:127] key from the repository, combinational function of round_count
- round_count  out  4  key index driven to the repository
- blk_start  in  1  pulse: stream keys for one block
- decrypt  in  1  sampled with blk_start; 1 = reverse order
- rk_out  out  128  [0:127] registered round key to the datapath
- rk_valid  out  1  rk_out holds a valid key
- rk_ready  in  1  datapath accepts rk_out
- rk_first  out  1  qualifies the first key of a block
- rk_last  out  1  qualifies the last key of a block
- key_ready  out  1  expanded key available, sequencer idle
- exp_err  out  1  expansion timeout pulse (tied 0 without the optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; idx 0; Nr 10.
- round_count equals the idx register at all times.
- Nr is latched when new_key is accepted:
  - keylength128 gives 10, else keylength192 gives 12, else keylength256 gives 14.
  - If none of the three is asserted, new_key is ignored.
- States:
  - IDLE: key_ready=0. On new_key, assert start_exp for one cycle and go to EXPAND.
  - EXPAND: first wait for busy_exp=1 (flag seen_busy), then for busy_exp=0, then go to READY. new_key and blk_start are ignored in this state.
  - READY: key_ready=1, idx=0.
    - new_key is accepted as in IDLE and has priority over blk_start in the same cycle.
    - On blk_start: latch dir=decrypt; idx <= dir ? Nr : 0; end_idx = dir ? 0 : Nr; go to RUN.
  - RUN: ld = !rk_valid | rk_ready.
    - If ld and keys remain: rk_out <= roundkey_in, rk_valid <= 1, rk_first <= (first key of the block), rk_last <= (idx==end_idx).
    - idx steps by +1 (encrypt) or -1 (decrypt) and never wraps past 0 or Nr.
    - If ld with no keys remaining: rk_valid <= 0 and go to READY.
    - Accepting the last key (rk_valid & rk_ready & rk_last) returns to READY in the same cycle. rk_valid drops the next cycle.
    - While rk_valid=1 and rk_ready=0, rk_out, rk_first, rk_last and idx hold.
    - new_key and blk_start are ignored in RUN.
- Latency:
  - blk_start at cycle T puts RUN in effect at T+1; first rk_valid at T+2.
  - With rk_ready held high, keys arrive one per cycle: Nr+1 keys per block, back-to-back.
- Reset mid-operation: asynchronous return to IDLE. Any stream in progress is discarded; key_ready=0 until a new expansion completes.
- busy_exp rising while in READY/RUN (a foreign expansion): ignored, but flagged in the bench as a protocol error.

Optional Feature:
- Macro KEY_SEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit EXPAND cycle counter runs, cleared on entry to EXPAND.
  - If TIMEOUT_CYC cycles elapse without busy_exp falling, go to IDLE and pulse exp_err for one cycle.
  - key_ready stays 0.
- Undefined: no counter; EXPAND waits indefinitely; exp_err is constant 0.

Test Plan:
- 128-bit key, new_key, repository busy for 11 cycles:
  - start_exp pulses exactly once.
  - key_ready rises the cycle after busy_exp falls.
  - blk_start with decrypt=0 produces 11 keys, round_count 0..10, with rk_first on key 0 and rk_last on key 10, one per cycle.
- 256-bit key, decrypt=1, rk_ready high: 15 keys in index order 14..0, rk_first on index 14, rk_last on index 0, then back to READY.
- 192-bit key, encrypt, rk_ready toggled 1,0,0,1...: rk_out and round_count hold during stalls; exactly 13 keys, none duplicated or skipped.
- blk_start and new_key asserted in the same cycle in READY: new_key wins, start_exp pulses, no rk_valid. new_key pulsed during RUN is ignored and the stream completes.
- arst_n asserted mid-stream (key 5 of 11): all outputs 0 immediately. After release, blk_start is ignored until a re-expansion completes.
- With KEY_SEQ_TIMEOUT_EN defined, busy_exp held high for 300 cycles: exp_err pulses at EXPAND cycle 255, state returns to IDLE, key_ready remains 0.

Source files
------------

// File: rtl/round_key_sequencer.sv
// Round key sequencer: requests key expansion from the repository, then streams round keys
// forward (encrypt) or reverse (decrypt) over valid/ready. Optional timeout: KEY_SEQ_TIMEOUT_EN.
module round_key_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic         mclk,
  input  logic         arst_n,
  input  logic         keylength128,
  input  logic         keylength192,
  input  logic         keylength256,
  input  logic         new_key,
  output logic         start_exp,
  input  logic         busy_exp,
  input  logic [0:127] roundkey_in,
  output logic [3:0]   round_count,
  input  logic         blk_start,
  input  logic         decrypt,
  output logic [0:127] rk_out,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_first,
  output logic         rk_last,
  output logic         key_ready,
  output logic         exp_err
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY, RUN} state_t;

  state_t     state;
  logic [3:0] idx;
  logic [3:0] nr;
  logic [3:0] end_idx;
  logic       dir;
  logic       seen_busy;
  logic       first;
  logic       more;
  logic       key_sel;
  logic [3:0] nr_sel;
  logic       ld;

`ifdef KEY_SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] exp_cnt;
`else
  // Constant 0; the parameter only matters when the timeout counter is built.
  assign exp_err = (TIMEOUT_CYC == 0) & 1'b0;
`endif

  // A new key is only meaningful with a key length; 128 wins over 192 over 256.
  always_comb begin
    key_sel = keylength128 | keylength192 | keylength256;
    if (keylength128)      nr_sel = 4'd10;
    else if (keylength192) nr_sel = 4'd12;
    else                   nr_sel = 4'd14;
  end

  assign ld          = !rk_valid | rk_ready;
  assign round_count = idx;

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      idx       <= 4'd0;
      nr        <= 4'd10;
      end_idx   <= 4'd0;
      dir       <= 1'b0;
      seen_busy <= 1'b0;
      first     <= 1'b0;
      more      <= 1'b0;
      start_exp <= 1'b0;
      rk_out    <= '0;
      rk_valid  <= 1'b0;
      rk_first  <= 1'b0;
      rk_last   <= 1'b0;
      key_ready <= 1'b0;
`ifdef KEY_SEQ_TIMEOUT_EN
      exp_cnt   <= 8'd0;
      exp_err   <= 1'b0;
`endif
    end else begin
      start_exp <= 1'b0;
`ifdef KEY_SEQ_TIMEOUT_EN
      exp_err   <= 1'b0;
`endif
      case (state)
        IDLE, READY: begin
          if (new_key && key_sel) begin
            nr        <= nr_sel;
            start_exp <= 1'b1;
            seen_busy <= 1'b0;
            key_ready <= 1'b0;
            idx       <= 4'd0;
`ifdef KEY_SEQ_TIMEOUT_EN
            exp_cnt   <= 8'd0;
`endif
            state     <= EXPAND;
          end else if (state == READY && blk_start) begin
            dir       <= decrypt;
            idx       <= decrypt ? nr : 4'd0;
            end_idx   <= decrypt ? 4'd0 : nr;
            first     <= 1'b1;
            more      <= 1'b1;
            key_ready <= 1'b0;
            state     <= RUN;
          end
        end
        EXPAND: begin
          if (!seen_busy) begin
            if (busy_exp) seen_busy <= 1'b1;
          end else if (!busy_exp) begin
            key_ready <= 1'b1;
            idx       <= 4'd0;
            state     <= READY;
          end
`ifdef KEY_SEQ_TIMEOUT_EN
          exp_cnt <= exp_cnt + 8'd1;
          if (exp_cnt == TIMEOUT_LAST && !(seen_busy && !busy_exp)) begin
            exp_err   <= 1'b1;
            key_ready <= 1'b0;
            state     <= IDLE;
          end
`endif
        end
        RUN: begin
          // Accepting the last key ends the block; nothing else is loaded after it.
          if ((rk_valid && rk_ready && rk_last) || (ld && !more)) begin
            rk_valid  <= 1'b0;
            rk_first  <= 1'b0;
            rk_last   <= 1'b0;
            idx       <= 4'd0;
            key_ready <= 1'b1;
            state     <= READY;
          end else if (ld) begin
            rk_out   <= roundkey_in;
            rk_valid <= 1'b1;
            rk_first <= first;
            rk_last  <= (idx == end_idx);
            first    <= 1'b0;
            if (idx == end_idx) more <= 1'b0;
            else if (dir)       idx  <= idx - 4'd1;
            else                idx  <= idx + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed bench for round_key_sequencer with a behavioural key repository.
// Define KEY_SEQ_TIMEOUT_EN to also exercise the expansion timeout.
module tb_round_key_sequencer;

  logic         mclk = 1'b0;
  logic         arst_n = 1'b0;
  logic         keylength128 = 1'b0;
  logic         keylength192 = 1'b0;
  logic         keylength256 = 1'b0;
  logic         new_key = 1'b0;
  logic         start_exp;
  logic         busy_exp = 1'b0;
  logic [0:127] roundkey_in;
  logic [3:0]   round_count;
  logic         blk_start = 1'b0;
  logic         decrypt = 1'b0;
  logic [0:127] rk_out;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic         rk_first;
  logic         rk_last;
  logic         key_ready;
  logic         exp_err;

  int tests = 0;
  int failed = 0;
  int start_cnt = 0;

  always #5 mclk = ~mclk;

  function automatic logic [0:127] key_of(input logic [3:0] i);
    return {8{4'hC, i, 4'h3, ~i}};
  endfunction

  assign roundkey_in = key_of(round_count);

  round_key_sequencer dut (
    .mclk(mclk), .arst_n(arst_n),
    .keylength128(keylength128), .keylength192(keylength192), .keylength256(keylength256),
    .new_key(new_key), .start_exp(start_exp), .busy_exp(busy_exp),
    .roundkey_in(roundkey_in), .round_count(round_count),
    .blk_start(blk_start), .decrypt(decrypt),
    .rk_out(rk_out), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_first(rk_first), .rk_last(rk_last),
    .key_ready(key_ready), .exp_err(exp_err)
  );

  always @(negedge mclk) if (start_exp) start_cnt++;

  // A repository expansion overlapping READY/RUN is a protocol error.
  always @(negedge mclk) begin
    if (arst_n && busy_exp && (key_ready || rk_valid)) begin
      failed++;
      $error("[TB] FAIL foreign_busy: busy_exp=1 with key_ready=%0b rk_valid=%0b", key_ready, rk_valid);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse new_key (optionally with blk_start) and model a repository busy for busy_len cycles.
  task automatic expand(input logic k128, input logic k192, input logic k256,
                        input int busy_len, input logic with_blk);
    int s0;
    s0 = start_cnt;
    keylength128 = k128;
    keylength192 = k192;
    keylength256 = k256;
    new_key = 1'b1;
    blk_start = with_blk;
    tick(1);
    new_key = 1'b0;
    blk_start = 1'b0;
    check_output("start_exp_pulse", start_exp, 1);
    check_output("key_ready_expand", key_ready, 0);
    check_output("no_valid_expand", rk_valid, 0);
    busy_exp = 1'b1;
    tick(1);
    check_output("start_exp_single", start_exp, 0);
    tick(busy_len - 1);
    busy_exp = 1'b0;
    check_output("key_ready_before_fall", key_ready, 0);
    tick(1);
    check_output("key_ready_rise", key_ready, 1);
    check_output("start_exp_count", start_cnt - s0, 1);
    check_output("rc_ready", round_count, 0);
  endtask

  // Stream one block; stall pattern 1 drives rk_ready 1,0,0 repeating. new_key pulsed at nk_at.
  task automatic apply_stimulus(input logic dec, input logic [3:0] nr, input int pat, input int nk_at);
    int k, first_cyc, last_cyc, s0;
    logic [3:0] exp_idx, nxt_idx;
    k = 0;
    first_cyc = -1;
    last_cyc = -1;
    s0 = start_cnt;
    decrypt = dec;
    blk_start = 1'b1;
    rk_ready = 1'b1;
    tick(1);
    blk_start = 1'b0;
    decrypt = 1'b0;
    for (int cyc = 0; cyc < 100 && k <= int'(nr); cyc++) begin
      rk_ready = (pat == 0) ? 1'b1 : (cyc % 3 == 0);
      new_key = (cyc == nk_at);
      @(negedge mclk);
      exp_idx = dec ? nr - 4'(k) : 4'(k);
      nxt_idx = (k == int'(nr)) ? exp_idx : (dec ? exp_idx - 4'd1 : exp_idx + 4'd1);
      if (!rk_valid) begin
        if (k == 0) check_output("rc_start", round_count, exp_idx);
        else        check_output("valid_gap", rk_valid, 1);
      end else begin
        if (first_cyc < 0) first_cyc = cyc;
        check_output("rk_out", rk_out, key_of(exp_idx));
        check_output("rk_first", rk_first, k == 0);
        check_output("rk_last", rk_last, k == int'(nr));
        check_output("rc_next", round_count, nxt_idx);
        if (rk_ready) begin
          last_cyc = cyc;
          k++;
        end
      end
      @(posedge mclk);
      #1;
    end
    new_key = 1'b0;
    rk_ready = 1'b1;
    check_output("key_count", k, int'(nr) + 1);
    check_output("first_latency", first_cyc, 1);
    check_output("valid_drop", rk_valid, 0);
    check_output("key_ready_after", key_ready, 1);
    check_output("rc_after", round_count, 0);
    check_output("no_start_in_run", start_cnt - s0, 0);
    if (pat == 0) check_output("back_to_back", last_cyc - first_cyc, int'(nr));
  endtask

  initial begin
    #12;
    check_output("rst_start_exp", start_exp, 0);
    check_output("rst_rk_valid", rk_valid, 0);
    check_output("rst_rk_out", rk_out, 0);
    check_output("rst_key_ready", key_ready, 0);
    check_output("rst_round_count", round_count, 0);
    check_output("rst_exp_err", exp_err, 0);
    arst_n = 1'b1;
    tick(2);

    // new_key without any key length is ignored
    new_key = 1'b1;
    tick(1);
    new_key = 1'b0;
    check_output("nolen_start_exp", start_exp, 0);
    tick(2);
    check_output("nolen_start_cnt", start_cnt, 0);

    // 128-bit encrypt, new_key pulsed mid-stream is ignored
    expand(1'b1, 1'b0, 1'b0, 11, 1'b0);
    apply_stimulus(1'b0, 4'd10, 0, 4);

    // 256-bit decrypt, back-to-back
    expand(1'b0, 1'b0, 1'b1, 5, 1'b0);
    apply_stimulus(1'b1, 4'd14, 0, -1);

    // 192 beats 256 when both set; encrypt with stalls
    expand(1'b0, 1'b1, 1'b1, 3, 1'b0);
    apply_stimulus(1'b0, 4'd12, 1, -1);

    // new_key beats blk_start in READY
    expand(1'b1, 1'b0, 1'b0, 4, 1'b1);
    apply_stimulus(1'b0, 4'd10, 0, -1);

    // reset mid-stream at key 5
    blk_start = 1'b1;
    tick(1);
    blk_start = 1'b0;
    tick(6);
    check_output("pre_rst_key5", rk_out, key_of(4'd5));
    check_output("pre_rst_rc", round_count, 6);
    #2 arst_n = 1'b0;
    #1;
    check_output("mid_rst_rk_valid", rk_valid, 0);
    check_output("mid_rst_rk_out", rk_out, 0);
    check_output("mid_rst_first_last", {rk_first, rk_last}, 0);
    check_output("mid_rst_key_ready", key_ready, 0);
    check_output("mid_rst_rc", round_count, 0);
    check_output("mid_rst_start_exp", start_exp, 0);
    #2 arst_n = 1'b1;
    tick(1);
    blk_start = 1'b1;
    tick(1);
    blk_start = 1'b0;
    tick(2);
    check_output("post_rst_no_valid", rk_valid, 0);
    check_output("post_rst_key_ready", key_ready, 0);
    check_output("post_rst_rc", round_count, 0);
    expand(1'b1, 1'b0, 1'b0, 2, 1'b0);
    apply_stimulus(1'b1, 4'd10, 0, -1);

`ifdef KEY_SEQ_TIMEOUT_EN
    begin
      int hit, err_cnt;
      hit = -1;
      err_cnt = 0;
      keylength128 = 1'b1;
      new_key = 1'b1;
      busy_exp = 1'b1;
      tick(1);
      new_key = 1'b0;
      for (int i = 1; i <= 300; i++) begin
        tick(1);
        if (exp_err === 1'b1) begin
          err_cnt++;
          if (hit < 0) hit = i;
        end
        if (key_ready === 1'b1) err_cnt += 100;
      end
      busy_exp = 1'b0;
      check_output("timeout_cycle", hit, 255);
      check_output("timeout_pulses", err_cnt, 1);
      check_output("timeout_key_ready", key_ready, 0);
      expand(1'b1, 1'b0, 1'b0, 3, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
